// File: rtl/ula_result_fifo.sv
// ula_result_fifo: show-ahead FIFO capturing ALU results; optional zero/neg flags under ULA_RESULT_FLAGS_EN
module ula_result_fifo #(
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_strobe,
  input  logic [7:0]    in_data,
  input  logic [3:0]    in_op,
  input  logic          clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic [3:0]    out_op,
  output logic          out_zero,
  output logic          out_neg,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          ovf
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [AW-1:0] wp, rp;
  logic [7:0] mem_d [DEPTH];
  logic [3:0] mem_op [DEPTH];
  logic push, pop;
  assign full = count == CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_strobe & ~full & ~clr;
  assign pop = out_valid & out_ready & ~clr;
  assign out_data = out_valid ? mem_d[rp] : '0;
  assign out_op = out_valid ? mem_op[rp] : '0;
  // pointers, occupancy and sticky overflow; clr outranks push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + CW'(push) - CW'(pop);
      ovf <= ovf | (in_strobe & full);
    end
  end
  // entry storage is never reset; it is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_d[wp] <= in_data;
      mem_op[wp] <= in_op;
    end
  end
`ifdef ULA_RESULT_FLAGS_EN
  logic [1:0] mem_f [DEPTH];
  // flags are derived once at capture so the read side stays a plain mux
  always_ff @(posedge clk) begin
    if (push) mem_f[wp] <= {in_data == 8'h00, in_data[7]};
  end
  assign out_zero = out_valid & mem_f[rp][1];
  assign out_neg = out_valid & mem_f[rp][0];
`else
  assign out_zero = 1'b0;
  assign out_neg = 1'b0;
`endif
endmodule

// File: tb/tb_ula_result_fifo.sv
// tb_ula_result_fifo: directed vector table plus reset/flush sequences for ula_result_fifo
module tb_ula_result_fifo;
  logic clk = 1'b0, rst_n = 1'b0, in_strobe = 1'b0, clr = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = '0;
  logic [3:0] in_op = '0;
  logic out_valid, out_zero, out_neg, full, ovf;
  logic [7:0] out_data;
  logic [3:0] out_op;
  logic [2:0] count;
  int n_run = 0, n_fail = 0;

  ula_result_fifo #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_strobe(in_strobe), .in_data(in_data), .in_op(in_op),
    .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_op(out_op), .out_zero(out_zero), .out_neg(out_neg), .count(count),
    .full(full), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic s; logic [7:0] d; logic [3:0] o; logic r; logic c;
    logic ev; logic [7:0] ed; logic [3:0] eo; logic [2:0] ecnt; logic ef; logic eovf;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [1:0] flags(input logic v, input logic [7:0] d);
`ifdef ULA_RESULT_FLAGS_EN
    return {v && d == 8'h00, v && d[7]};
`else
    return 2'b00;
`endif
  endfunction

  task automatic add(input logic s, input logic [7:0] d, input logic [3:0] o, input logic r,
                     input logic c, input logic ev, input logic [7:0] ed, input logic [3:0] eo,
                     input logic [2:0] ecnt, input logic ef, input logic eovf);
    vec_t v;
    v.s = s; v.d = d; v.o = o; v.r = r; v.c = c;
    v.ev = ev; v.ed = ed; v.eo = eo; v.ecnt = ecnt; v.ef = ef; v.eovf = eovf;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic ev, input logic [7:0] ed, input logic [3:0] eo,
                       input logic [2:0] ecnt, input logic ef, input logic eovf);
    logic [19:0] act, exp;
    act = {out_valid, out_data, out_op, count, full, ovf, out_zero, out_neg};
    exp = {ev, ed, eo, ecnt, ef, eovf, flags(ev, ed)};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b d=%h o=%h cnt=%0d full=%b ovf=%b z=%b n=%b, want v=%b d=%h o=%h cnt=%0d full=%b ovf=%b z=%b n=%b",
               name, act[19], act[18:11], act[10:7], act[6:4], act[3], act[2], act[1], act[0],
               exp[19], exp[18:11], exp[10:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] d, input logic [3:0] o, input logic r, input logic c);
    in_strobe = s; in_data = d; in_op = o; out_ready = r; clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    add(1, 8'h3C, 4'h0, 0, 0, 1, 8'h3C, 4'h0, 1, 0, 0);
    add(0, 8'h00, 4'h0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    add(1, 8'h00, 4'h1, 0, 0, 1, 8'h00, 4'h1, 1, 0, 0);
    add(1, 8'h80, 4'h4, 0, 0, 1, 8'h00, 4'h1, 2, 0, 0);
    add(0, 8'h00, 4'h0, 1, 0, 1, 8'h80, 4'h4, 1, 0, 0);
    add(0, 8'h00, 4'h0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    add(1, 8'h01, 4'h5, 0, 0, 1, 8'h01, 4'h5, 1, 0, 0);
    add(1, 8'h02, 4'h6, 0, 0, 1, 8'h01, 4'h5, 2, 0, 0);
    add(1, 8'h03, 4'h7, 0, 0, 1, 8'h01, 4'h5, 3, 0, 0);
    add(1, 8'h04, 4'h8, 0, 0, 1, 8'h01, 4'h5, 4, 1, 0);
    add(1, 8'h05, 4'h9, 0, 0, 1, 8'h01, 4'h5, 4, 1, 1);
    add(1, 8'h06, 4'hA, 1, 0, 1, 8'h02, 4'h6, 3, 0, 1);
    add(0, 8'h00, 4'h0, 1, 0, 1, 8'h03, 4'h7, 2, 0, 1);
    add(0, 8'h00, 4'h0, 1, 0, 1, 8'h04, 4'h8, 1, 0, 1);
    add(0, 8'h00, 4'h0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 1);
    add(0, 8'h00, 4'h0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 1);
    add(1, 8'hAA, 4'hF, 0, 0, 1, 8'hAA, 4'hF, 1, 0, 1);
    add(1, 8'hBB, 4'hE, 0, 0, 1, 8'hAA, 4'hF, 2, 0, 1);
    add(1, 8'hCC, 4'hD, 0, 0, 1, 8'hAA, 4'hF, 3, 0, 1);
    add(1, 8'hDD, 4'hC, 1, 1, 0, 8'h00, 4'h0, 0, 0, 0);
    add(1, 8'h11, 4'h1, 0, 0, 1, 8'h11, 4'h1, 1, 0, 0);
    add(1, 8'h22, 4'h2, 0, 0, 1, 8'h11, 4'h1, 2, 0, 0);
    add(1, 8'h33, 4'h3, 1, 0, 1, 8'h22, 4'h2, 2, 0, 0);
    add(1, 8'h44, 4'h4, 1, 0, 1, 8'h33, 4'h3, 2, 0, 0);
    add(1, 8'h55, 4'h5, 1, 0, 1, 8'h44, 4'h4, 2, 0, 0);
    add(1, 8'h66, 4'h6, 1, 0, 1, 8'h55, 4'h5, 2, 0, 0);
    add(1, 8'h77, 4'h7, 1, 0, 1, 8'h66, 4'h6, 2, 0, 0);
    add(1, 8'h88, 4'h8, 1, 0, 1, 8'h77, 4'h7, 2, 0, 0);
    add(0, 8'h00, 4'h0, 1, 0, 1, 8'h88, 4'h8, 1, 0, 0);
    add(0, 8'h00, 4'h0, 1, 0, 0, 8'h00, 4'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", 0, 8'h00, 4'h0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].d, tbl[i].o, tbl[i].r, tbl[i].c);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eo, tbl[i].ecnt, tbl[i].ef, tbl[i].eovf);
    end
    step(1, 8'h5A, 4'h2, 0, 0);
    step(1, 8'h6B, 4'h3, 0, 0);
    check("pre_rst", 1, 8'h5A, 4'h2, 2, 0, 0);
    in_strobe = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", 0, 8'h00, 4'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00, 4'h0, 1, 0);
    check("post_rst_empty", 0, 8'h00, 4'h0, 0, 0, 0);
    step(1, 8'h9C, 4'h3, 0, 0);
    check("post_rst_push", 1, 8'h9C, 4'h3, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ula_result_fifo.md
ULA_RESULT_FIFO -- requirements
Module: ula_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count, power of two, 2..16.
REQ-002 The block SHALL have parameter CW, default $clog2(DEPTH)+1, meaning width of the count output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_strobe  input  1  capture request for the current ALU result.
REQ-006 in_data  input  8  ALU result (out of the ula stage).
REQ-007 in_op  input  4  ALU select s that produced in_data.
REQ-008 clr  input  1  synchronous flush.
REQ-009 out_valid  output  1  head entry present.
REQ-010 out_ready  input  1  consumer accepts head entry.
REQ-011 out_data  output  8  head entry result.
REQ-012 out_op  output  4  head entry opcode.
REQ-013 out_zero  output  1  head entry result equals 8'h00.
REQ-014 out_neg  output  1  head entry result bit 7.
REQ-015 count  output  CW  entries stored, 0..DEPTH.
REQ-016 full  output  1  count == DEPTH.
REQ-017 ovf  output  1  sticky: a strobe was dropped because the FIFO was full.

Function
REQ-018 Push occurs when in_strobe=1, full=0 and clr=0: {in_data, in_op, flags} written at write pointer, pointer +1 modulo DEPTH.
REQ-019 Pop occurs when out_valid=1, out_ready=1 and clr=0: read pointer +1 modulo DEPTH.
REQ-020 Show-ahead: out_data/out_op/out_zero/out_neg reflect the head entry combinationally from storage whenever out_valid=1; with out_valid=0 they SHALL be driven 0.
REQ-021 Latency: a push at edge N makes the entry visible with out_valid=1 after edge N; no same-cycle bypass from in_data to out_data.
REQ-022 out_valid SHALL equal (count != 0).
REQ-023 Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
REQ-024 Push while full SHALL be dropped even if a pop occurs in the same cycle; count decrements by the pop only; ovf set to 1.
REQ-025 Pop request while empty (out_ready=1, out_valid=0) SHALL be ignored; no pointer movement.
REQ-026 in_op values 5..15 SHALL be stored unmodified; no opcode checking.
REQ-027 clr=1 SHALL reset both pointers and count to 0 and clear ovf at the next edge; clr has priority over a simultaneous push or pop.
REQ-028 ovf SHALL remain 1 until clr or reset.

Reset
REQ-029 On rst_n=0, asynchronously: pointers=0, count=0, ovf=0, hence out_valid=0, full=0, out_data/out_op/out_zero/out_neg=0.
REQ-030 Storage array contents need not be reset; they are never visible while count=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; first edge after rst_n rises behaves as empty FIFO.

Configuration
REQ-032 Macro ULA_RESULT_FLAGS_EN defined: zero and neg flags computed from in_data at push time, stored per entry, presented on out_zero/out_neg.
REQ-033 Macro ULA_RESULT_FLAGS_EN undefined: no flag storage; out_zero and out_neg SHALL be tied 0; all other behaviour identical.

Verification
REQ-034 Reset, then push 8'h3C op 4'h0 -> next cycle out_valid=1, out_data=8'h3C, out_op=4'h0, count=1, out_zero=0, out_neg=0.
REQ-035 Push 8'h00 op 1 then 8'h80 op 4 (flags enabled), pop both -> heads show (zero=1,neg=0) then (zero=0,neg=1), count back to 0, out_valid=0.
REQ-036 DEPTH=4: push 5 values 8'h01..8'h05 with out_ready=0 -> full=1, count=4, ovf=1, pops return 01,02,03,04; 05 absent.
REQ-037 Count=2, in_strobe=1 and out_ready=1 in same cycle for 6 cycles -> count stays 2, outputs in push order, pointers wrap without data loss.
REQ-038 Count=3, ovf=1, assert clr with in_strobe=1 -> next cycle count=0, ovf=0, out_valid=0; async rst_n pulse mid-stream -> all outputs 0 immediately.
